// File: rtl/digit_pattern_gen.sv
// Seven-segment digit raster generator: scans a WIDTH x HEIGHT frame, one pixel per en cycle, black inside lit segments.
// Latency: one cycle from an accepted pixel to oValid; optional macro PATGEN_LOOP_EN chains frames when start is held in DONE.
module digit_pattern_gen #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int STROKE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        start,
  input  logic [3:0]  iDigital,
  input  logic [19:0] iBox_Row,
  input  logic [19:0] iBox_Col,
  output logic [9:0]  oRow,
  output logic [9:0]  oCol,
  output logic [9:0]  oBWData,
  output logic [19:0] oEdge_Row,
  output logic [19:0] oEdge_Col,
  output logic        oValid,
  output logic        oBusy,
  output logic        oDone
);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  localparam logic [9:0]  LAST_COL = 10'(WIDTH - 1);
  localparam logic [9:0]  LAST_ROW = 10'(HEIGHT - 1);
  localparam logic [11:0] SW       = 12'(STROKE);
  localparam logic [11:0] HALF     = 12'(STROKE / 2);
  localparam logic [11:0] FRAME_W  = 12'(WIDTH);
  localparam logic [11:0] FRAME_H  = 12'(HEIGHT);

  state_t      state_q;
  logic [3:0]  digit_q;
  logic [19:0] box_row_q;
  logic [19:0] box_col_q;
  logic [9:0]  row_q;
  logic [9:0]  col_q;
  logic [9:0]  row_out_q;
  logic [9:0]  col_out_q;
  logic [9:0]  bw_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;

  logic [11:0] r, c, top, bot, lft, rgt, mid;
  logic        row_top, row_bot, row_mid, row_upper, row_lower;
  logic        col_full, col_l, col_r;
  logic [6:0]  segs;
  logic [6:0]  hit;
  logic        box_ok;
  logic        black_d;
  logic [9:0]  bw_d;

  // Geometry is evaluated at 12 bits so top+bottom and the +STROKE offsets never wrap.
  always_comb begin
    r   = {2'b00, row_q};
    c   = {2'b00, col_q};
    top = {2'b00, box_row_q[9:0]};
    bot = {2'b00, box_row_q[19:10]};
    lft = {2'b00, box_col_q[9:0]};
    rgt = {2'b00, box_col_q[19:10]};
    mid = (top + bot) >> 1;

    row_top   = (r >= top) && (r < top + SW);
    row_bot   = (r + SW > bot) && (r <= bot);
    row_mid   = (r + HALF >= mid) && (r + HALF < mid + SW);
    row_upper = (r >= top) && (r <= mid);
    row_lower = (r >= mid) && (r <= bot);
    col_full  = (c >= lft) && (c <= rgt);
    col_l     = (c >= lft) && (c < lft + SW);
    col_r     = (c + SW > rgt) && (c <= rgt);

    // Bit order {a,b,c,d,e,f,g}.
    hit = {row_top & col_full, row_upper & col_r, row_lower & col_r,
           row_bot & col_full, row_lower & col_l, row_upper & col_l,
           row_mid & col_full};

    segs = 7'b0000000;
    case (digit_q)
      4'd0:    segs = 7'b1111110;
      4'd1:    segs = 7'b0110000;
      4'd2:    segs = 7'b1101101;
      4'd3:    segs = 7'b1111001;
      4'd4:    segs = 7'b0110011;
      4'd5:    segs = 7'b1011011;
      4'd6:    segs = 7'b1011111;
      4'd7:    segs = 7'b1110000;
      4'd8:    segs = 7'b1111111;
      4'd9:    segs = 7'b1111011;
      default: segs = 7'b0000000;
    endcase

    box_ok = (digit_q <= 4'd9) && (top + (SW << 1) <= bot) && (lft + (SW << 1) <= rgt)
             && (bot < FRAME_H) && (rgt < FRAME_W);

    black_d = box_ok && ((segs & hit) != 7'b0000000);
    bw_d    = black_d ? 10'h000 : 10'h3FF;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      digit_q   <= 4'd0;
      box_row_q <= 20'd0;
      box_col_q <= 20'd0;
      row_q     <= 10'd0;
      col_q     <= 10'd0;
      row_out_q <= 10'd0;
      col_out_q <= 10'd0;
      bw_q      <= 10'h3FF;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            digit_q   <= iDigital;
            box_row_q <= iBox_Row;
            box_col_q <= iBox_Col;
            row_q     <= 10'd0;
            col_q     <= 10'd0;
            busy_q    <= 1'b1;
            state_q   <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (en) begin
            row_out_q <= row_q;
            col_out_q <= col_q;
            bw_q      <= bw_d;
            valid_q   <= 1'b1;
            if (col_q == LAST_COL) begin
              col_q <= 10'd0;
              if (row_q == LAST_ROW) begin
                row_q   <= 10'd0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                row_q <= row_q + 10'd1;
              end
            end else begin
              col_q <= col_q + 10'd1;
            end
          end
        end
        S_DONE: begin
`ifdef PATGEN_LOOP_EN
          if (start) begin
            row_q   <= 10'd0;
            col_q   <= 10'd0;
            state_q <= S_DRAW;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
`else
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
`endif
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign oRow      = row_out_q;
  assign oCol      = col_out_q;
  assign oBWData   = bw_q;
  assign oEdge_Row = box_row_q;
  assign oEdge_Col = box_col_q;
  assign oValid    = valid_q;
  assign oBusy     = busy_q;
  assign oDone     = done_q;

endmodule

// File: tb/tb_digit_pattern_gen.sv
// Directed bench for digit_pattern_gen on a reduced 40x36 frame; expected pixels come from a segment model queued at start.
module tb_digit_pattern_gen;

  localparam int W = 40;
  localparam int H = 36;
  localparam int S = 4;
`ifdef PATGEN_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        start;
  logic [3:0]  iDigital;
  logic [19:0] iBox_Row;
  logic [19:0] iBox_Col;
  logic [9:0]  oRow, oCol, oBWData;
  logic [19:0] oEdge_Row, oEdge_Col;
  logic        oValid, oBusy, oDone;

  int n_checks = 0;
  int n_errors = 0;

  logic [29:0] sb[$];
  int          pt_r[$];
  int          pt_c[$];
  logic [9:0]  pt_v[$];
  logic [19:0] cur_brow, cur_bcol;

  localparam logic [19:0] B_ROW = {10'd30, 10'd10};
  localparam logic [19:0] B_COL = {10'd32, 10'd20};

  digit_pattern_gen #(.WIDTH(W), .HEIGHT(H), .STROKE(S)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
    .iDigital(iDigital), .iBox_Row(iBox_Row), .iBox_Col(iBox_Col),
    .oRow(oRow), .oCol(oCol), .oBWData(oBWData),
    .oEdge_Row(oEdge_Row), .oEdge_Col(oEdge_Col),
    .oValid(oValid), .oBusy(oBusy), .oDone(oDone)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rect(input int r, input int c, input int r0, input int r1,
                                 input int c0, input int c1);
    return (r >= r0) && (r <= r1) && (c >= c0) && (c <= c1);
  endfunction

  function automatic logic [9:0] model_bw(input logic [3:0] dig, input logic [19:0] brow,
                                          input logic [19:0] bcol, input int r, input int c);
    int top, bot, lft, rgt, mid, glo;
    logic [6:0] segs;
    bit lit;
    top = int'(brow[9:0]);
    bot = int'(brow[19:10]);
    lft = int'(bcol[9:0]);
    rgt = int'(bcol[19:10]);
    mid = (top + bot) / 2;
    glo = mid - S / 2;
    case (dig)
      4'd0: segs = 7'b1111110;
      4'd1: segs = 7'b0110000;
      4'd2: segs = 7'b1101101;
      4'd3: segs = 7'b1111001;
      4'd4: segs = 7'b0110011;
      4'd5: segs = 7'b1011011;
      4'd6: segs = 7'b1011111;
      4'd7: segs = 7'b1110000;
      4'd8: segs = 7'b1111111;
      4'd9: segs = 7'b1111011;
      default: segs = 7'b0000000;
    endcase
    if (dig > 4'd9 || top + 2 * S > bot || lft + 2 * S > rgt || bot >= H || rgt >= W)
      return 10'h3FF;
    lit = 1'b0;
    if (segs[6] && in_rect(r, c, top, top + S - 1, lft, rgt))         lit = 1'b1;
    if (segs[5] && in_rect(r, c, top, mid, rgt - S + 1, rgt))         lit = 1'b1;
    if (segs[4] && in_rect(r, c, mid, bot, rgt - S + 1, rgt))         lit = 1'b1;
    if (segs[3] && in_rect(r, c, bot - S + 1, bot, lft, rgt))         lit = 1'b1;
    if (segs[2] && in_rect(r, c, mid, bot, lft, lft + S - 1))         lit = 1'b1;
    if (segs[1] && in_rect(r, c, top, mid, lft, lft + S - 1))         lit = 1'b1;
    if (segs[0] && in_rect(r, c, glo, glo + S - 1, lft, rgt))         lit = 1'b1;
    return lit ? 10'h000 : 10'h3FF;
  endfunction

  task automatic push_frame(input logic [3:0] dig, input logic [19:0] brow, input logic [19:0] bcol);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        sb.push_back({10'(r), 10'(c), model_bw(dig, brow, bcol, r, c)});
  endtask

  task automatic add_pt(input int r, input int c, input logic [9:0] v);
    pt_r.push_back(r);
    pt_c.push_back(c);
    pt_v.push_back(v);
  endtask

  task automatic clear_pts();
    pt_r.delete();
    pt_c.delete();
    pt_v.delete();
  endtask

  task automatic start_frame(input logic [3:0] dig, input logic [19:0] brow,
                             input logic [19:0] bcol, input bit hold);
    push_frame(dig, brow, bcol);
    cur_brow = brow;
    cur_bcol = bcol;
    @(negedge clk);
    iDigital = dig;
    iBox_Row = brow;
    iBox_Col = bcol;
    start    = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    check("busy_on_start", 32'(oBusy), 32'(1));
    check("edge_row", 32'(oEdge_Row), 32'(brow));
    check("edge_col", 32'(oEdge_Col), 32'(bcol));
  endtask

  // mode 0: en held high, 1: en toggling, 2: en high plus a stray start mid-frame
  task automatic run_frame(input int mode, input bit hold);
    int pulses = 0;
    int cyc = 0;
    bit fin = 1'b0;
    logic [29:0] got, last, exp;
    last = '0;
    en = 1'b1;
    while (!fin && cyc < 4 * W * H + 20) begin
      @(negedge clk);
      cyc++;
      got = {oRow, oCol, oBWData};
      if (oValid) begin
        pulses++;
        check("sb_nonempty", 32'(sb.size() > 0), 32'(1));
        if (sb.size() > 0) begin
          exp = sb.pop_front();
          check("pixel", 32'(got), 32'(exp));
        end
        for (int i = 0; i < pt_r.size(); i++)
          if (int'(oRow) == pt_r[i] && int'(oCol) == pt_c[i])
            check("point", 32'(oBWData), 32'(pt_v[i]));
        last = got;
      end else if (pulses > 0) begin
        check("hold", 32'(got), 32'(last));
      end
      if (oDone) begin
        fin = 1'b1;
        check("done_last", 32'(sb.size()), 32'(0));
        check("done_busy", 32'(oBusy), 32'(1));
        check("pulses", 32'(pulses), 32'(W * H));
        check("edge_hold", 32'({oEdge_Row, oEdge_Col} != {cur_brow, cur_bcol}), 32'(0));
      end
      case (mode)
        1: en = ~en;
        2: begin
          en = 1'b1;
          if (cyc == 100) begin
            start    = 1'b1;
            iDigital = 4'd1;
            iBox_Row = {10'd20, 10'd2};
          end else begin
            start = 1'b0;
          end
        end
        default: en = 1'b1;
      endcase
    end
    check("frame_done_seen", 32'(fin), 32'(1));
    @(negedge clk);
    check("done_single", 32'(oDone), 32'(0));
    check("busy_after", 32'(oBusy), 32'(hold & LOOP));
    if (hold) start = 1'b0;
    clear_pts();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_row"},   32'(oRow),      32'(0));
    check({tag, "_col"},   32'(oCol),      32'(0));
    check({tag, "_bw"},    32'(oBWData),   32'(10'h3FF));
    check({tag, "_erow"},  32'(oEdge_Row), 32'(0));
    check({tag, "_ecol"},  32'(oEdge_Col), 32'(0));
    check({tag, "_valid"}, 32'(oValid),    32'(0));
    check({tag, "_busy"},  32'(oBusy),     32'(0));
    check({tag, "_done"},  32'(oDone),     32'(0));
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; start = 1'b0;
    iDigital = 4'd0; iBox_Row = '0; iBox_Col = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;

    // Digit 8 with reference points scaled to the reduced frame.
    add_pt(10, 25, 10'h000); add_pt(15, 25, 10'h3FF); add_pt(15, 22, 10'h000);
    add_pt(20, 26, 10'h000); add_pt(9, 25, 10'h3FF);
    start_frame(4'd8, B_ROW, B_COL, 1'b0);
    run_frame(0, 1'b0);

    add_pt(15, 22, 10'h3FF); add_pt(15, 31, 10'h000); add_pt(25, 31, 10'h000);
    start_frame(4'd1, B_ROW, B_COL, 1'b0);
    run_frame(0, 1'b0);

    add_pt(20, 26, 10'h3FF);
    start_frame(4'd7, B_ROW, B_COL, 1'b0);
    run_frame(0, 1'b0);

    // Remaining digits on assorted boxes, including the tightest legal box and frame-edge boxes.
    start_frame(4'd0, {10'd33, 10'd2}, {10'd38, 10'd1}, 1'b0);  run_frame(0, 1'b0);
    start_frame(4'd2, {10'd13, 10'd5}, {10'd11, 10'd3}, 1'b0);  run_frame(0, 1'b0);
    start_frame(4'd3, {10'd35, 10'd0}, {10'd39, 10'd25}, 1'b0); run_frame(0, 1'b0);
    start_frame(4'd4, B_ROW, B_COL, 1'b0);                      run_frame(0, 1'b0);
    start_frame(4'd6, {10'd33, 10'd2}, {10'd38, 10'd1}, 1'b0);  run_frame(0, 1'b0);
    start_frame(4'd9, {10'd31, 10'd3}, {10'd30, 10'd4}, 1'b0);  run_frame(0, 1'b0);

    start_frame(4'd5, B_ROW, B_COL, 1'b0);
    run_frame(1, 1'b0);

    // Degenerate requests: frame timing unchanged, all pixels white.
    add_pt(10, 25, 10'h3FF);
    start_frame(4'd12, B_ROW, B_COL, 1'b0);                     run_frame(0, 1'b0);
    add_pt(10, 25, 10'h3FF);
    start_frame(4'd8, {10'd10, 10'd30}, B_COL, 1'b0);           run_frame(0, 1'b0);
    start_frame(4'd8, {10'd36, 10'd10}, B_COL, 1'b0);           run_frame(0, 1'b0);
    start_frame(4'd8, B_ROW, {10'd40, 10'd20}, 1'b0);           run_frame(0, 1'b0);
    start_frame(4'd8, {10'd12, 10'd5}, {10'd11, 10'd3}, 1'b0);  run_frame(0, 1'b0);

    start_frame(4'd8, B_ROW, B_COL, 1'b0);
    run_frame(2, 1'b0);

    // start held through a frame: chains when looping is built in, otherwise idles for a cycle.
    start = 1'b0;
    start_frame(4'd2, B_ROW, B_COL, 1'b1);
    run_frame(0, 1'b1);
    if (oBusy) begin
      push_frame(4'd2, B_ROW, B_COL);
    end else begin
      start_frame(4'd2, B_ROW, B_COL, 1'b0);
    end
    run_frame(0, 1'b0);

    // Abort mid-frame with reset, then restart from pixel (0,0).
    start_frame(4'd8, B_ROW, B_COL, 1'b0);
    begin
      bit hit_px = 1'b0;
      logic [29:0] e;
      en = 1'b1;
      for (int k = 0; k < 2 * W * H && !hit_px; k++) begin
        @(negedge clk);
        if (oValid && sb.size() > 0) begin
          e = sb.pop_front();
          check("abort_pixel", 32'({oRow, oCol, oBWData}), 32'(e));
          if (oRow == 10'd20 && oCol == 10'd10) hit_px = 1'b1;
        end
      end
      check("abort_reached", 32'(hit_px), 32'(1));
      rst = 1'b0;
      #1;
      check_reset_vals("abort");
      sb.delete();
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check("abort_no_done", 32'(oDone), 32'(0));
      end
      rst = 1'b1;
    end
    start_frame(4'd3, B_ROW, B_COL, 1'b0);
    run_frame(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
